// File: rtl/load_ctrl.sv
// Load unit: issues one data-memory read per load, formats the returned word,
// and reports either the extended data or a load trap back to the pipeline.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   load_valid/ready   load offer from the pipeline (mem_op, load_addr)
//   flush              abandon the current load
//   dmem_*             single-outstanding read port (req/gnt, rvalid/rdata/err)
//   result_*           result handshake with formatted data
//   load_trap_*        trap flag and mcause accompanying a result

package params_pkg;
  localparam logic [4:0] MEM_NOP = 5'd0;
  localparam logic [4:0] MEM_LB  = 5'd1;
  localparam logic [4:0] MEM_LH  = 5'd2;
  localparam logic [4:0] MEM_LW  = 5'd3;
  localparam logic [4:0] MEM_LBU = 5'd4;
  localparam logic [4:0] MEM_LHU = 5'd5;
  localparam logic [4:0] MEM_SB  = 5'd6;
  localparam logic [4:0] MEM_SH  = 5'd7;
  localparam logic [4:0] MEM_SW  = 5'd8;

  localparam logic [30:0] TRAP_CODE_LOAD_ADDR_MISALIGNED = 31'd4;
  localparam logic [30:0] TRAP_CODE_LOAD_ACCESS_FAULT    = 31'd5;
endpackage

module load_ctrl
  import params_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [4:0]  mem_op,
  input  logic [31:0] load_addr,
  input  logic        flush,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_err,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result_rdata,
  output logic        load_trap_valid,
  output logic [30:0] load_trap_mcause
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t      state_q;
  logic [4:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] rdata_q;
  logic        trap_q;
  logic [30:0] cause_q;

  logic        in_lb, in_lh, in_lw;
  logic        in_lbu, in_lhu;
  logic        in_load;
  logic        in_misal;

  always_comb begin
    in_lb  = (mem_op == MEM_LB);
    in_lh  = (mem_op == MEM_LH);
    in_lw  = (mem_op == MEM_LW);
    in_lbu = (mem_op == MEM_LBU);
    in_lhu = (mem_op == MEM_LHU);
    in_load = in_lb | in_lh | in_lw
            | in_lbu | in_lhu;
    in_misal = ((in_lh | in_lhu) & load_addr[0])
             | (in_lw & (load_addr[1:0] != 2'b00));
  end

  logic [31:0] sh_b;
  logic [31:0] sh_h;
  logic [7:0]  b_sel;
  logic [15:0] h_sel;
  logic [31:0] fmt_data;

  // Byte lane k = addr[1:0], half lane h = addr[1].
  always_comb begin
    sh_b  = dmem_rdata >> {addr_q[1:0], 3'b000};
    sh_h  = dmem_rdata >> {addr_q[1], 4'b0000};
    b_sel = sh_b[7:0];
    h_sel = sh_h[15:0];
    fmt_data = 32'h0;
    unique case (1'b1)
      (op_q == MEM_LB):
        fmt_data = {{24{b_sel[7]}}, b_sel};
      (op_q == MEM_LBU):
        fmt_data = {24'h0, b_sel};
      (op_q == MEM_LH):
        fmt_data = {{16{h_sel[15]}}, h_sel};
      (op_q == MEM_LHU):
        fmt_data = {16'h0, h_sel};
      (op_q == MEM_LW):
        fmt_data = dmem_rdata;
      default:
        fmt_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= MEM_NOP;
      addr_q  <= 32'h0;
      rdata_q <= 32'h0;
      trap_q  <= 1'b0;
      cause_q <= 31'h0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!flush && load_valid && in_load) begin
            op_q   <= mem_op;
            addr_q <= load_addr;
            if (in_misal) begin
              // Misaligned: trap straight away, memory untouched.
              rdata_q <= 32'h0;
              trap_q  <= 1'b1;
              cause_q <= TRAP_CODE_LOAD_ADDR_MISALIGNED;
              state_q <= S_RESP;
            end else begin
              state_q <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (flush) begin
            // A grant in the flush cycle still leaves
            // a response in flight that must be absorbed.
            state_q <= dmem_gnt ? S_DRAIN : S_IDLE;
          end else if (dmem_gnt) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            state_q <= dmem_rvalid ? S_IDLE : S_DRAIN;
          end else if (dmem_rvalid) begin
            state_q <= S_RESP;
            if (dmem_err) begin
              rdata_q <= 32'h0;
              trap_q  <= 1'b1;
              cause_q <= TRAP_CODE_LOAD_ACCESS_FAULT;
            end else begin
              rdata_q <= fmt_data;
              trap_q  <= 1'b0;
              cause_q <= 31'h0;
            end
          end
        end
        S_RESP: begin
          if (flush || result_ready) begin
            state_q <= S_IDLE;
            rdata_q <= 32'h0;
            trap_q  <= 1'b0;
            cause_q <= 31'h0;
          end
        end
        S_DRAIN: begin
          // Flush here changes nothing: the
          // outstanding beat must still be absorbed.
          if (dmem_rvalid) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  logic in_resp;

  always_comb begin
    in_resp          = (state_q == S_RESP);
    load_ready       = (state_q == S_IDLE);
    dmem_req         = (state_q == S_REQ);
    dmem_addr        = dmem_req
                     ? {addr_q[31:2], 2'b00}
                     : 32'h0;
    result_valid     = in_resp;
    result_rdata     = in_resp ? rdata_q : 32'h0;
    load_trap_valid  = in_resp & trap_q;
    load_trap_mcause = in_resp ? cause_q : 31'h0;
  end

endmodule

// File: tb/tb_load_ctrl.sv
// Bench for load_ctrl: transaction-level reference model, directed
// scenarios with literal expectations, then randomized traffic.

module tb_load_ctrl;
  import params_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  mem_op;
  logic [31:0] load_addr;
  logic        flush;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        dmem_err;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result_rdata;
  logic        load_trap_valid;
  logic [30:0] load_trap_mcause;

  int n_cmp = 0;
  int n_bad = 0;

  load_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .load_valid       (load_valid),
    .load_ready       (load_ready),
    .mem_op           (mem_op),
    .load_addr        (load_addr),
    .flush            (flush),
    .dmem_req         (dmem_req),
    .dmem_addr        (dmem_addr),
    .dmem_gnt         (dmem_gnt),
    .dmem_rvalid      (dmem_rvalid),
    .dmem_rdata       (dmem_rdata),
    .dmem_err         (dmem_err),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .result_rdata     (result_rdata),
    .load_trap_valid  (load_trap_valid),
    .load_trap_mcause (load_trap_mcause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the load unit owes, as transaction flags.
  bit          m_req;   // request to be presented to memory
  bit          m_out;   // request granted, response pending
  bit          m_drop;  // pending response must be thrown away
  bit          m_res;   // result held for the pipeline
  bit          m_trap;
  logic [4:0]  m_op;
  logic [31:0] m_addr;
  logic [31:0] m_rd;
  logic [30:0] m_cause;

  function automatic bit is_load(logic [4:0] op);
    return op == MEM_LB || op == MEM_LH || op == MEM_LW
        || op == MEM_LBU || op == MEM_LHU;
  endfunction

  function automatic bit misal(logic [4:0] op, logic [31:0] a);
    return ((op == MEM_LH || op == MEM_LHU) && (a % 2 != 0))
        || (op == MEM_LW && (a % 4 != 0));
  endfunction

  function automatic logic [31:0] fmt(logic [4:0] op,
                                      logic [31:0] a,
                                      logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (op)
      MEM_LB:  return (b >= 32'd128) ? b - 32'd256 : b;
      MEM_LBU: return b;
      MEM_LH:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      MEM_LHU: return h;
      MEM_LW:  return w;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req   <= 1'b0;
      m_out   <= 1'b0;
      m_drop  <= 1'b0;
      m_res   <= 1'b0;
      m_trap  <= 1'b0;
      m_op    <= 5'd0;
      m_addr  <= 32'h0;
      m_rd    <= 32'h0;
      m_cause <= 31'h0;
    end else if (m_res) begin
      if (flush || result_ready) m_res <= 1'b0;
    end else if (m_req) begin
      if (dmem_gnt) begin
        m_req  <= 1'b0;
        m_out  <= 1'b1;
        m_drop <= flush;
      end else if (flush) begin
        m_req <= 1'b0;
      end
    end else if (m_out) begin
      if (dmem_rvalid) begin
        m_out  <= 1'b0;
        m_drop <= 1'b0;
        if (!m_drop && !flush) begin
          m_res   <= 1'b1;
          m_trap  <= dmem_err;
          m_cause <= dmem_err ? TRAP_CODE_LOAD_ACCESS_FAULT : 31'h0;
          m_rd    <= dmem_err ? 32'h0 : fmt(m_op, m_addr, dmem_rdata);
        end
      end else if (flush) begin
        m_drop <= 1'b1;
      end
    end else if (!flush && load_valid && is_load(mem_op)) begin
      m_op   <= mem_op;
      m_addr <= load_addr;
      if (misal(mem_op, load_addr)) begin
        m_res   <= 1'b1;
        m_trap  <= 1'b1;
        m_cause <= TRAP_CODE_LOAD_ADDR_MISALIGNED;
        m_rd    <= 32'h0;
      end else begin
        m_req <= 1'b1;
      end
    end
  end

  function automatic logic [98:0] exp_vec();
    logic idle;
    idle = !(m_req || m_out || m_res);
    return {idle, m_req,
            m_req ? (m_addr & 32'hFFFF_FFFC) : 32'h0,
            m_res, m_res ? m_rd : 32'h0,
            m_res && m_trap, m_res ? m_cause : 31'h0};
  endfunction

  function automatic logic [98:0] dut_vec();
    return {load_ready, dmem_req, dmem_addr,
            result_valid, result_rdata,
            load_trap_valid, load_trap_mcause};
  endfunction

  task automatic compare();
    logic [98:0] e;
    logic [98:0] a;
    e = exp_vec();
    a = dut_vec();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL outputs t=%0t got %h want %h", $time, a, e);
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle_in();
    load_valid   = 1'b0;
    mem_op       = MEM_NOP;
    load_addr    = 32'h0;
    flush        = 1'b0;
    dmem_gnt     = 1'b0;
    dmem_rvalid  = 1'b0;
    dmem_rdata   = 32'h0;
    dmem_err     = 1'b0;
    result_ready = 1'b0;
  endtask

  task automatic offer(logic [4:0] op, logic [31:0] a);
    load_valid = 1'b1;
    mem_op     = op;
    load_addr  = a;
    tick();
    load_valid = 1'b0;
    mem_op     = MEM_NOP;
  endtask

  task automatic consume();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  logic [4:0] ops [8] = '{MEM_LB, MEM_LH, MEM_LW, MEM_LBU,
                          MEM_LHU, MEM_SB, MEM_SW, MEM_NOP};
  bit mbusy;
  int mwait;

  initial begin
    rst_n = 1'b0;
    idle_in();
    repeat (2) @(negedge clk);
    compare();
    chk("rst_ready", load_ready, 1);
    chk("rst_req", dmem_req, 0);
    chk("rst_valid", result_valid, 0);
    rst_n = 1'b1;
    tick();

    // LB sign extension, top byte
    offer(MEM_LB, 32'h1003);
    chk("lb_req", dmem_req, 1);
    chk("lb_addr", dmem_addr, 32'h1000);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h80FF_FFFF;
    tick();
    dmem_rvalid = 1'b0;
    chk("lb_valid", result_valid, 1);
    chk("lb_data", result_rdata, 32'hFFFF_FF80);
    chk("lb_model", m_rd, 32'hFFFF_FF80);
    chk("lb_trap", load_trap_valid, 0);
    consume();
    chk("lb_done", load_ready, 1);

    // LHU upper half, zero extended
    offer(MEM_LHU, 32'h2002);
    chk("lhu_addr", dmem_addr, 32'h2000);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h8001_1234;
    tick();
    dmem_rvalid = 1'b0;
    chk("lhu_data", result_rdata, 32'h0000_8001);
    chk("lhu_model", m_rd, 32'h0000_8001);
    consume();

    // misaligned LW traps next cycle
    offer(MEM_LW, 32'h3001);
    chk("mis_valid", result_valid, 1);
    chk("mis_trap", load_trap_valid, 1);
    chk("mis_cause", load_trap_mcause, 32'd4);
    chk("mis_req", dmem_req, 0);
    chk("mis_data", result_rdata, 0);
    consume();

    // grant withheld, then access fault
    offer(MEM_LW, 32'h4000);
    for (int i = 0; i < 3; i++) begin
      chk("hold_addr", dmem_addr, 32'h4000);
      tick();
    end
    chk("hold_addr4", dmem_addr, 32'h4000);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_err    = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    tick();
    dmem_rvalid = 1'b0;
    dmem_err    = 1'b0;
    chk("err_trap", load_trap_valid, 1);
    chk("err_cause", load_trap_mcause, 32'd5);
    chk("err_data", result_rdata, 0);
    consume();

    // flush while waiting, response absorbed
    offer(MEM_LW, 32'h5000);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    chk("drain_ready", load_ready, 0);
    chk("drain_req", dmem_req, 0);
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_2222;
    tick();
    dmem_rvalid = 1'b0;
    chk("drain_valid", result_valid, 0);
    chk("drain_ready2", load_ready, 1);

    // result held under backpressure
    offer(MEM_LBU, 32'h6001);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_AB56;
    tick();
    dmem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", result_rdata, 32'h0000_00AB);
      chk("bp_ready", load_ready, 0);
      tick();
    end
    consume();
    chk("bp_idle", load_ready, 1);

    // async reset in WAIT, late response ignored
    offer(MEM_LW, 32'h7000);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    compare();
    chk("arst_ready", load_ready, 1);
    chk("arst_req", dmem_req, 0);
    chk("arst_addr", dmem_addr, 0);
    @(negedge clk);
    rst_n       = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_AAAA;
    tick();
    dmem_rvalid = 1'b0;
    chk("late_valid", result_valid, 0);
    chk("late_ready", load_ready, 1);

    // randomized traffic
    mbusy = 1'b0;
    mwait = 0;
    for (int c = 0; c < 4000; c++) begin
      dmem_rvalid = 1'b0;
      dmem_err    = 1'b0;
      dmem_rdata  = $urandom;
      if (mbusy) begin
        if (mwait == 0) begin
          dmem_rvalid = 1'b1;
          dmem_err    = ($urandom_range(0, 5) == 0);
          mbusy       = 1'b0;
        end else begin
          mwait--;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        dmem_rvalid = 1'b1;
      end
      dmem_gnt = dmem_req && ($urandom_range(0, 2) != 0);
      if (dmem_gnt) begin
        mbusy = 1'b1;
        mwait = $urandom_range(0, 2);
      end
      load_valid   = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0)
        mem_op = 5'($urandom_range(0, 31));
      else
        mem_op = ops[$urandom_range(0, 7)];
      load_addr    = $urandom;
      flush        = ($urandom_range(0, 9) == 0);
      result_ready = $urandom_range(0, 1);
      tick();
    end

    idle_in();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
